// File: rtl/div_defs.sv
// Shared constants for the sequential divider: operand width, iteration counter width
// and FSM state encodings.
package div_defs;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned CntWidth = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from a 33-bit partial
// remainder, keeping the difference only when it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_part_rem,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_next_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_sel;

  assign w_diff  = i_part_rem - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH];
  assign w_sel   = o_q_bit ? w_diff : i_part_rem;
  // A kept remainder is always below the divisor, so the top bit is always zero.
  assign o_next_rem = w_sel[WIDTH-1:0];

endmodule

// File: rtl/seq_divider32.sv
// Radix-2 restoring divider, signed/unsigned, 32 iterations plus a sign-fix cycle;
// results are registered and flagged by a one-cycle done pulse.
module seq_divider32
  import div_defs::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e          r_state, w_state_next;
  logic [WIDTH-1:0]    r_quo, r_rem, r_div;
  logic [WIDTH-1:0]    r_quotient, r_remainder;
  logic [CntWidth-1:0] r_cnt;
  logic                r_neg_q, r_neg_r, r_dbz, r_done, r_div_by_zero;

  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_next_rem;
  logic             w_q_bit;

  assign w_a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (signed_op && B[WIDTH-1]) ? -B : B;

  // r_quo starts as the dividend magnitude; its MSB shifts into the remainder each step.
  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_part_rem({r_rem, r_quo[WIDTH-1]}),
    .i_divisor (r_div),
    .o_next_rem(w_next_rem),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start) w_state_next = (B == '0) ? StDone : StCalc;
      StCalc:  if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo         <= '0;
      r_rem         <= '0;
      r_div         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= (r_state == StDone);
      case (r_state)
        StIdle: begin
          if (start) begin
            r_neg_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r <= signed_op & A[WIDTH-1];
            r_div   <= w_b_mag;
            r_cnt   <= CntWidth'(WIDTH - 1);
            if (B == '0) begin
              r_quo <= '1;
              r_rem <= A;
              r_dbz <= 1'b1;
            end else begin
              r_quo <= w_a_mag;
              r_rem <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        StCalc: begin
          r_rem <= w_next_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
        end
        StFix: begin
          if (r_neg_q) r_quo <= -r_quo;
          if (r_neg_r) r_rem <= -r_rem;
        end
        StDone: begin
          r_quotient    <= r_quo;
          r_remainder   <= r_rem;
          r_div_by_zero <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign done        = r_done;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32; latency is counted in clock edges
// from the start-sampling edge to the first edge after which done is seen high.
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .A          (A),
    .B          (B),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Returns #1 after the edge that samples start (edge 0).
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; signed_op = s; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watches a bounded window; cycles stays -1 if done never rises.
  task automatic wait_done(output int cycles, output int busy_cycles, output int pulses);
    cycles = -1; pulses = 0;
    busy_cycles = busy ? 1 : 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      if (done) begin
        pulses++;
        if (cycles < 0) cycles = n;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient); end
    n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder); end
    n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_unsigned();
    int cyc, bc, dp;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(cyc, bc, dp);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL basic_latency: got %0d want 34", cyc); end
    n_checks++; if (bc !== 34) begin n_fail++; $display("FAIL basic_busy: got %0d want 34", bc); end
    n_checks++; if (dp !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", dp); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int cyc, bc, dp;
    for (int s = 0; s < 2; s++) begin
      start_op(s[0], 32'h12345678, 32'h0);
      wait_done(cyc, bc, dp);
      n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency[%0d]: got %0d want 1", s, cyc); end
      n_checks++; if (dp !== 1) begin n_fail++; $display("FAIL dbz_pulses[%0d]: got %0d want 1", s, dp); end
      n_checks++; if (quotient !== 32'hFFFFFFFF) begin
        n_fail++; $display("FAIL dbz_q[%0d]: got %h want ffffffff", s, quotient);
      end
      n_checks++; if (remainder !== 32'h12345678) begin
        n_fail++; $display("FAIL dbz_r[%0d]: got %h want 12345678", s, remainder);
      end
      n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag[%0d]: got %b want 1", s, div_by_zero); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, bc, dp;
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 32'd5; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    // Previous divide-by-zero results must still be held mid-operation.
    n_checks++; if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL hold_q: got %h want ffffffff", quotient); end
    n_checks++; if (remainder !== 32'h12345678) begin n_fail++; $display("FAIL hold_r: got %h want 12345678", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL hold_dbz: got %b want 1", div_by_zero); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
    wait_done(cyc, bc, dp);
    n_checks++; if (cyc !== 23) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 23", cyc); end
    n_checks++; if (dp !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d want 1", dp); end
    n_checks++; if (quotient !== 32'd333) begin n_fail++; $display("FAIL busy_start_q: got %0d want 333", quotient); end
    n_checks++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL busy_start_r: got %0d want 1", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL busy_start_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_vectors();
    logic        vs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] va[7] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFF9C, 32'hFFFFFFFF,
                           32'h80000000, 32'hFFFFFFFF, 32'h00000064};
    logic [31:0] vb[7] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h00010000,
                           32'hFFFFFFFF, 32'h00000001, 32'h00000007};
    logic [31:0] vq[7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0000000E, 32'h0000FFFF,
                           32'h80000000, 32'hFFFFFFFF, 32'h0000000E};
    logic [31:0] vr[7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h0000FFFF,
                           32'h00000000, 32'h00000000, 32'h00000002};
    int cyc, bc, dp;
    for (int i = 0; i < 7; i++) begin
      start_op(vs[i], va[i], vb[i]);
      wait_done(cyc, bc, dp);
      n_checks++; if (quotient !== vq[i]) begin n_fail++; $display("FAIL vec_q[%0d]: got %h want %h", i, quotient, vq[i]); end
      n_checks++; if (remainder !== vr[i]) begin n_fail++; $display("FAIL vec_r[%0d]: got %h want %h", i, remainder, vr[i]); end
      n_checks++; if (cyc !== 34 || div_by_zero !== 1'b0) begin
        n_fail++; $display("FAIL vec_lat_dbz[%0d]: got %0d/%b want 34/0", i, cyc, div_by_zero);
      end
    end
  endtask

  task automatic test_start_in_done();
    int cyc, bc, dp;
    start_op(1'b0, 32'd77, 32'd10);
    repeat (33) @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 32'd50; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_cycle_done: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_busy: got %b want 0", busy); end
    n_checks++; if (quotient !== 32'd7 || remainder !== 32'd7) begin
      n_fail++; $display("FAIL done_cycle_result: got %0d/%0d want 7/7", quotient, remainder);
    end
    wait_done(cyc, bc, dp);
    n_checks++; if (dp !== 0 || bc !== 0) begin
      n_fail++; $display("FAIL done_cycle_ignored: got pulses %0d busy %0d want 0/0", dp, bc);
    end
    start_op(1'b0, 32'd52, 32'd5);
    wait_done(cyc, bc, dp);
    n_checks++; if (cyc !== 34 || quotient !== 32'd10 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL after_done_op: got %0d %0d/%0d want 34 10/2", cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_calc();
    int cyc, bc, dp;
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin
      n_fail++; $display("FAIL midrst_result: got %h/%h want 0/0", quotient, remainder);
    end
    n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags: got %b want 000", {busy, done, div_by_zero});
    end
    @(negedge clk); rst = 1'b0;
    start_op(1'b0, 32'd9, 32'd4);
    wait_done(cyc, bc, dp);
    n_checks++; if (cyc !== 34 || dp !== 1) begin
      n_fail++; $display("FAIL midrst_restart: got latency %0d pulses %0d want 34/1", cyc, dp);
    end
    n_checks++; if (quotient !== 32'd2 || remainder !== 32'd1) begin
      n_fail++; $display("FAIL midrst_result2: got %0d/%0d want 2/1", quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic_unsigned();
    test_div_by_zero();
    test_start_while_busy();
    test_vectors();
    test_start_in_done();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
